// File: rtl/bias_group_sequencer.sv
// Adds the active output-channel group's bias word to each adder-tree beat with
// saturation and steps groups across a layer. Optional fused ReLU: BIAS_GROUP_SEQ_RELU_EN.

module bias_lane_add #(
   parameter int DATA_W = 18
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_y
);
   localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_sat;

   assign w_sum = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};

   // Overflow shows up as disagreement between the two top bits of the wide sum.
   always_comb begin
      w_sat = w_sum[DATA_W-1:0];
      if (w_sum[DATA_W] != w_sum[DATA_W-1]) w_sat = w_sum[DATA_W] ? MINV : MAXV;
   end

`ifdef BIAS_GROUP_SEQ_RELU_EN
   assign o_y = w_sat[DATA_W-1] ? '0 : w_sat;
`else
   assign o_y = w_sat;
`endif
endmodule

module bias_group_sequencer #(
   parameter int N_adder_tree  = 16,
   parameter int DATA_W        = 18,
   parameter int NUM_GROUPS    = 4,
   parameter int PIX_PER_GROUP = 64,
   localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
   localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic                                      i_start,
   input  logic [NUM_GROUPS*N_adder_tree*DATA_W-1:0] i_bias_bus,
   input  logic                                      i_in_valid,
   output logic                                      o_in_ready,
   input  logic [N_adder_tree*DATA_W-1:0]            i_in_data,
   output logic                                      o_out_valid,
   input  logic                                      i_out_ready,
   output logic [N_adder_tree*DATA_W-1:0]            o_out_data,
   output logic [GW-1:0]                             o_group_idx,
   output logic                                      o_busy,
   output logic                                      o_layer_done
);
   localparam int RW = N_adder_tree * DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                               r_state, w_state_nxt;
   logic                                 r_out_valid, r_layer_done;
   logic [RW-1:0]                        r_out_data;
   logic [GW-1:0]                        r_group;
   logic [PW-1:0]                        r_pix;
   logic [RW-1:0]                        w_bias_sel;
   logic [N_adder_tree-1:0][DATA_W-1:0]  w_sum;
   logic                                 w_in_ready, w_acc_in, w_acc_out;
   logic                                 w_last_pix, w_last_grp, w_last;

   assign w_in_ready = (r_state == S_RUN) & (~r_out_valid | i_out_ready);
   assign w_acc_in   = i_in_valid & w_in_ready;
   assign w_acc_out  = r_out_valid & i_out_ready;
   assign w_last_pix = (r_pix == PW'(PIX_PER_GROUP - 1));
   assign w_last_grp = (r_group == GW'(NUM_GROUPS - 1));
   assign w_last     = w_acc_in & w_last_pix & w_last_grp;

   always_comb begin
      w_bias_sel = '0;
      for (int g = 0; g < NUM_GROUPS; g++)
         if (r_group == GW'(g)) w_bias_sel = i_bias_bus[RW*g +: RW];
   end

   for (genvar l = 0; l < N_adder_tree; l++) begin : g_lane
      bias_lane_add #(.DATA_W(DATA_W)) u_lane (
         .i_a (i_in_data[DATA_W*l +: DATA_W]),
         .i_b (w_bias_sel[DATA_W*l +: DATA_W]),
         .o_y (w_sum[l])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start)   w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_acc_out) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   // group_idx parks on the last group through DRAIN and is cleared on the final handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_group      <= '0;
         r_pix        <= '0;
         r_layer_done <= 1'b0;
      end else begin
         r_layer_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_group <= '0;
                  r_pix   <= '0;
               end
            end
            S_RUN: begin
               if (w_acc_in) begin
                  r_out_data  <= w_sum;
                  r_out_valid <= 1'b1;
                  if (w_last_pix) begin
                     r_pix <= '0;
                     if (!w_last_grp) r_group <= r_group + 1'b1;
                  end else begin
                     r_pix <= r_pix + 1'b1;
                  end
               end else if (w_acc_out) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (w_acc_out) begin
                  r_out_valid  <= 1'b0;
                  r_layer_done <= 1'b1;
                  r_group      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = r_out_valid;
   assign o_out_data   = r_out_data;
   assign o_group_idx  = r_group;
   assign o_busy       = (r_state == S_RUN) | (r_state == S_DRAIN);
   assign o_layer_done = r_layer_done;
endmodule

// File: tb/tb_bias_group_sequencer.sv
// Randomised bench for bias_group_sequencer against a beat-count reference model
// (3 groups x 4 beats per layer, saturation and ReLU expectations included).

module tb_bias_group_sequencer;
   localparam int N     = 16;
   localparam int DW    = 18;
   localparam int NG    = 3;
   localparam int PPG   = 4;
   localparam int TOTAL = NG * PPG;
   localparam int W     = N * DW;
   localparam int GW    = 2;
   localparam int MAXV  = (1 << (DW - 1)) - 1;
   localparam int MINV  = -(1 << (DW - 1));
`ifdef BIAS_GROUP_SEQ_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_start, i_in_valid, i_out_ready;
   logic [NG*W-1:0] bias_bus;
   logic [W-1:0]    i_in_data;
   logic            o_in_ready, o_out_valid, o_busy, o_layer_done;
   logic [W-1:0]    o_out_data;
   logic [GW-1:0]   o_group_idx;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit           m_busy, m_ov, m_done;
   int           m_acc;
   logic [W-1:0] q[$];

   always #5 clk = ~clk;

   bias_group_sequencer #(
      .N_adder_tree(N), .DATA_W(DW), .NUM_GROUPS(NG), .PIX_PER_GROUP(PPG)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_bias_bus(bias_bus),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_group_idx(o_group_idx), .o_busy(o_busy), .o_layer_done(o_layer_done)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic lane_chk(input string tag, input int idx, input int exp);
      logic [DW-1:0] e;
      logic [DW-1:0] g;
      e = DW'(exp);
      g = o_out_data[DW*idx +: DW];
      chk(tag, W'(g), W'(e));
   endtask

   function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input int grp);
      logic [W-1:0] r;
      int a, b, s;
      r = '0;
      for (int l = 0; l < N; l++) begin
         a = $signed(d[DW*l +: DW]);
         b = $signed(bias_bus[DW*(grp*N+l) +: DW]);
         s = a + b;
         if (s > MAXV) s = MAXV;
         if (s < MINV) s = MINV;
         if (RELU && s < 0) s = 0;
         r[DW*l +: DW] = DW'(s);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] fill(input int v);
      logic [W-1:0] r;
      for (int l = 0; l < N; l++) r[DW*l +: DW] = DW'(v);
      return r;
   endfunction

   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] r;
      for (int l = 0; l < N; l++)
         case ($urandom_range(0, 3))
            0:       r[DW*l +: DW] = DW'(MAXV);
            1:       r[DW*l +: DW] = DW'(MINV);
            2:       r[DW*l +: DW] = DW'(int'($urandom_range(0, 600)) - 300);
            default: r[DW*l +: DW] = DW'($urandom);
         endcase
      return r;
   endfunction

   // Called at a falling edge: drive, check, let one rising edge pass, advance the model.
   task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic st);
      bit exp_rdy, acc_in, acc_out, was_busy, done_nxt;
      i_in_valid = v; i_in_data = d; i_out_ready = ordy; i_start = st;
      #1;
      exp_rdy = m_busy && (m_acc < TOTAL) && (!m_ov || ordy);
      chk("in_ready", W'(o_in_ready), W'(exp_rdy));
      chk("out_valid", W'(o_out_valid), W'(m_ov));
      chk("busy", W'(o_busy), W'(m_busy));
      chk("layer_done", W'(o_layer_done), W'(m_done));
      if (m_acc < TOTAL) chk("group_idx", W'(o_group_idx), W'(m_acc / PPG));
      if (m_ov) chk("out_data", o_out_data, q[0]);
      acc_in   = v && exp_rdy;
      acc_out  = m_ov && ordy;
      was_busy = m_busy;
      done_nxt = 1'b0;
      @(posedge clk);
      if (acc_out) begin
         void'(q.pop_front());
         m_ov = 1'b0;
         if (m_acc == TOTAL) begin
            done_nxt = 1'b1; m_busy = 1'b0; m_acc = 0;
         end
      end
      if (acc_in) begin
         q.push_back(ref_beat(d, m_acc / PPG));
         m_acc++;
         m_ov = 1'b1;
      end
      if (!was_busy && st) begin
         m_busy = 1'b1; m_acc = 0;
      end
      m_done = done_nxt;
      @(negedge clk);
   endtask

   task automatic do_reset();
      i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      m_busy = 1'b0; m_ov = 1'b0; m_done = 1'b0; m_acc = 0; q.delete();
      chk("rst_out_valid", W'(o_out_valid), '0);
      chk("rst_out_data", o_out_data, '0);
      chk("rst_in_ready", W'(o_in_ready), '0);
      chk("rst_busy", W'(o_busy), '0);
      chk("rst_group_idx", W'(o_group_idx), '0);
      chk("rst_layer_done", W'(o_layer_done), '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic finish_layer(input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0);
         seen = m_done;
      end
      chk("layer_done_seen", W'(seen), W'(1'b1));
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_in_data = '0;
      for (int i = 0; i < NG * N; i++) bias_bus[DW*i +: DW] = DW'($urandom);
      bias_bus[DW*0 +: DW]       = DW'(-148);
      bias_bus[DW*1 +: DW]       = DW'(2488);
      bias_bus[DW*(N+2) +: DW]   = DW'(10);
      bias_bus[DW*(N+3) +: DW]   = DW'(-10);
      bias_bus[DW*(N+4) +: DW]   = '0;
      @(negedge clk);
      do_reset();

      // in_valid while idle must not be consumed
      for (int i = 0; i < 3; i++) step(1'b1, rand_data(), 1'b1, 1'b0);

      // partial layer interrupted by reset after 10 beats
      step(1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, rand_data(), 1'b1, 1'b0);
      do_reset();

      // directed layer: basic bias, spurious start, saturation, backpressure
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, fill(100), 1'b1, 1'b0);
      lane_chk("basic_lane0", 0, RELU ? 0 : -48);
      lane_chk("basic_lane1", 1, 2588);
      for (int i = 0; i < 3; i++) step(1'b1, rand_data(), 1'b1, 1'b1);
      begin
         logic [W-1:0] sd;
         sd = fill(100);
         sd[DW*2 +: DW] = DW'(MAXV);
         sd[DW*3 +: DW] = DW'(MINV);
         sd[DW*4 +: DW] = DW'(-5);
         step(1'b1, sd, 1'b1, 1'b0);
      end
      lane_chk("sat_hi", 2, MAXV);
      lane_chk("sat_lo", 3, RELU ? 0 : MINV);
      lane_chk("neg_small", 4, RELU ? 0 : -5);
      for (int i = 0; i < 5; i++) step(1'b1, rand_data(), 1'b0, 1'b0);
      finish_layer(300);

      // fully randomised layers
      for (int k = 0; k < 3; k++) begin
         step(1'b0, '0, 1'b1, 1'b1);
         finish_layer(400);
      end

      for (int i = 0; i < 3; i++) step(1'b1, rand_data(), 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
